block_task_dispatcher: RTL and testbench

//  Downstream of the inter-layer block scheduler. Accepts one schedule decision: which block goes to the
//  NPU and which to the in-pipeline CIM, plus each block's layer range. Issues per-layer tasks to both

---
 rtl/block_task_dispatcher_pkg.sv | 26 ++
 rtl/block_task_dispatcher_layer_issue_seq.sv | 85 ++++++++
 rtl/block_task_dispatcher.sv | 154 +++++++++++++++
 tb/tb_block_task_dispatcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/block_task_dispatcher_pkg.sv
// Shared encodings for the block task dispatcher: schedule/block types, compute kinds and FSM states.
package block_task_dispatcher_pkg;

    localparam logic       BLOCK0_CIM_BLOCK1_NPU = 1'b0;
    localparam logic       BLOCK0_NPU_BLOCK1_CIM = 1'b1;

    // Bit 1 selects block0 direction, bit 0 selects block1 direction (1 = backward).
    localparam logic [1:0] FORWARD_FORWARD       = 2'b00;
    localparam logic [1:0] FORWARD_BACKWARD      = 2'b01;
    localparam logic [1:0] BACKWARD_FORWARD      = 2'b10;
    localparam logic [1:0] BACKWARD_BACKWARD     = 2'b11;

    localparam logic [7:0] FORWARD_COMPUTE       = 8'h01;
    localparam logic [7:0] BACKWARD_COMPUTE      = 8'h02;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_FINISH} top_state_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} seq_state_e;

    function automatic logic [7:0] block_kind(input logic [1:0] block_type, input logic blk);
        logic bwd;
        bwd = blk ? (block_type == FORWARD_BACKWARD || block_type == BACKWARD_BACKWARD)
                  : (block_type == BACKWARD_FORWARD || block_type == BACKWARD_BACKWARD);
        return bwd ? BACKWARD_COMPUTE : FORWARD_COMPUTE;
    endfunction

endpackage

// File: rtl/block_task_dispatcher_layer_issue_seq.sv
// Per-engine layer sequencer: issues one task per layer, waits for its done pulse, then moves on.
module layer_issue_seq
    import block_task_dispatcher_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              go_i,
    input  logic              release_i,
    input  logic [31:0]       start_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [7:0]        kind_i,
    output logic              task_valid_o,
    output logic [ADDR_W-1:0] task_addr_o,
    input  logic              task_ready_i,
    input  logic              task_done_i,
    output logic              done_o
);

    seq_state_e        state_reg;
    logic [CNT_W-1:0]  idx_reg;
    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W:0]    idx_inc;

    // One extra bit so a full-range count terminates instead of wrapping.
    assign idx_inc = {1'b0, idx_reg} + (CNT_W+1)'(1);

    function automatic logic [ADDR_W-1:0] task_addr(input logic [CNT_W-1:0] idx);
        return ADDR_W'({kind_i, 8'h00}) + ADDR_W'(start_i) + ADDR_W'(idx);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (go_i) begin
                        idx_reg <= '0;
                        if (count_i == '0) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_ISSUE;
                            valid_reg <= 1'b1;
                            addr_reg  <= task_addr('0);
                        end
                    end
                end
                S_ISSUE: begin
                    if (task_ready_i) begin
                        valid_reg <= 1'b0;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (task_done_i) begin
                        if (idx_inc == {1'b0, count_i}) begin
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_inc[CNT_W-1:0];
                            addr_reg  <= task_addr(idx_inc[CNT_W-1:0]);
                            valid_reg <= 1'b1;
                            state_reg <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (release_i) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign task_valid_o = valid_reg;
    assign task_addr_o  = addr_reg;
    assign done_o       = (state_reg == S_DONE);

endmodule

// File: rtl/block_task_dispatcher.sv
// Block task dispatcher top: captures a schedule decision and drives the NPU and CIM sequencers.
// Optional DISPATCH_PERF_EN adds a bubble-cycle counter output.
module block_task_dispatcher
    import block_task_dispatcher_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sched_valid_i,
    output logic              sched_ready_o,
    input  logic              schedule_type_i,
    input  logic [1:0]        block_type_i,
    input  logic [31:0]       block0_start_i,
    input  logic [31:0]       block1_start_i,
    input  logic [CNT_W-1:0]  block0_count_i,
    input  logic [CNT_W-1:0]  block1_count_i,
    output logic              npu_task_valid_o,
    input  logic              npu_task_ready_i,
    output logic [ADDR_W-1:0] npu_task_addr_o,
    input  logic              npu_done_i,
    output logic              cim_task_valid_o,
    input  logic              cim_task_ready_i,
    output logic [ADDR_W-1:0] cim_task_addr_o,
    input  logic              cim_done_i,
    output logic              schedule_finish_o
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]       perf_bubble_cycles_o
`endif
);

    top_state_e       state_reg;
    logic             ready_reg;
    logic             finish_reg;
    logic             type_reg;
    logic [1:0]       btype_reg;
    logic [31:0]      b0_start_reg, b1_start_reg;
    logic [CNT_W-1:0] b0_count_reg, b1_count_reg;

    logic             hs;
    logic             npu_seq_done, cim_seq_done;

    assign hs = sched_valid_i & ready_reg;

    // While idle the sequencers see the live inputs so they can start on the handshake edge itself.
    logic             cur_type;
    logic [1:0]       cur_btype;
    logic [31:0]      cur_s0, cur_s1;
    logic [CNT_W-1:0] cur_c0, cur_c1;
    logic             cim_is_b0;

    assign cur_type  = ready_reg ? schedule_type_i : type_reg;
    assign cur_btype = ready_reg ? block_type_i    : btype_reg;
    assign cur_s0    = ready_reg ? block0_start_i  : b0_start_reg;
    assign cur_s1    = ready_reg ? block1_start_i  : b1_start_reg;
    assign cur_c0    = ready_reg ? block0_count_i  : b0_count_reg;
    assign cur_c1    = ready_reg ? block1_count_i  : b1_count_reg;
    assign cim_is_b0 = (cur_type == BLOCK0_CIM_BLOCK1_NPU);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= T_IDLE;
            ready_reg    <= 1'b1;
            finish_reg   <= 1'b0;
            type_reg     <= 1'b0;
            btype_reg    <= '0;
            b0_start_reg <= '0;
            b1_start_reg <= '0;
            b0_count_reg <= '0;
            b1_count_reg <= '0;
        end else begin
            finish_reg <= 1'b0;
            case (state_reg)
                T_IDLE: begin
                    if (hs) begin
                        type_reg     <= schedule_type_i;
                        btype_reg    <= block_type_i;
                        b0_start_reg <= block0_start_i;
                        b1_start_reg <= block1_start_i;
                        b0_count_reg <= block0_count_i;
                        b1_count_reg <= block1_count_i;
                        ready_reg    <= 1'b0;
                        state_reg    <= T_RUN;
                    end
                end
                T_RUN: begin
                    if (npu_seq_done && cim_seq_done) begin
                        finish_reg <= 1'b1;
                        state_reg  <= T_FINISH;
                    end
                end
                T_FINISH: begin
                    ready_reg <= 1'b1;
                    state_reg <= T_IDLE;
                end
                default: state_reg <= T_IDLE;
            endcase
        end
    end

    assign sched_ready_o     = ready_reg;
    assign schedule_finish_o = finish_reg;

    layer_issue_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_npu_seq (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .go_i         (hs),
        .release_i    (state_reg == T_FINISH),
        .start_i      (cim_is_b0 ? cur_s1 : cur_s0),
        .count_i      (cim_is_b0 ? cur_c1 : cur_c0),
        .kind_i       (block_kind(cur_btype, cim_is_b0)),
        .task_valid_o (npu_task_valid_o),
        .task_addr_o  (npu_task_addr_o),
        .task_ready_i (npu_task_ready_i),
        .task_done_i  (npu_done_i),
        .done_o       (npu_seq_done)
    );

    layer_issue_seq #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_cim_seq (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .go_i         (hs),
        .release_i    (state_reg == T_FINISH),
        .start_i      (cim_is_b0 ? cur_s0 : cur_s1),
        .count_i      (cim_is_b0 ? cur_c0 : cur_c1),
        .kind_i       (block_kind(cur_btype, !cim_is_b0)),
        .task_valid_o (cim_task_valid_o),
        .task_addr_o  (cim_task_addr_o),
        .task_ready_i (cim_task_ready_i),
        .task_done_i  (cim_done_i),
        .done_o       (cim_seq_done)
    );

`ifdef DISPATCH_PERF_EN
    logic [31:0] bubble_reg;

    // Bubble = one engine already drained while the other is still working.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_reg <= '0;
        end else if (hs) begin
            bubble_reg <= '0;
        end else if (state_reg == T_RUN && (npu_seq_done ^ cim_seq_done)
                     && bubble_reg != 32'hFFFF_FFFF) begin
            bubble_reg <= bubble_reg + 32'd1;
        end
    end

    assign perf_bubble_cycles_o = bubble_reg;
`endif

endmodule

// File: tb/tb_block_task_dispatcher.sv
// Directed bench for block_task_dispatcher: engine responders record accepted task addresses.
module tb_block_task_dispatcher;
    import block_task_dispatcher_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sched_valid_i = 1'b0;
    logic        sched_ready_o;
    logic        schedule_type_i = 1'b0;
    logic [1:0]  block_type_i = 2'b00;
    logic [31:0] block0_start_i = '0, block1_start_i = '0;
    logic [7:0]  block0_count_i = '0, block1_count_i = '0;
    logic        npu_task_valid_o, cim_task_valid_o;
    logic        npu_task_ready_i = 1'b1, cim_task_ready_i = 1'b1;
    logic [31:0] npu_task_addr_o, cim_task_addr_o;
    logic        npu_done_i = 1'b0, cim_done_i = 1'b0;
    logic        schedule_finish_o;
`ifdef DISPATCH_PERF_EN
    logic [31:0] perf_bubble_cycles_o;
`endif

    int          total = 0;
    int          bad = 0;
    int          latency = 2;
    int          npu_pend = 0, cim_pend = 0;
    int          finish_cnt = 0;
    int          n_npu0, n_cim0, fin0;
    logic [31:0] npu_q[$];
    logic [31:0] cim_q[$];

    always #5 clk_i = ~clk_i;

    block_task_dispatcher #(.CNT_W(8), .ADDR_W(32)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .sched_valid_i     (sched_valid_i),
        .sched_ready_o     (sched_ready_o),
        .schedule_type_i   (schedule_type_i),
        .block_type_i      (block_type_i),
        .block0_start_i    (block0_start_i),
        .block1_start_i    (block1_start_i),
        .block0_count_i    (block0_count_i),
        .block1_count_i    (block1_count_i),
        .npu_task_valid_o  (npu_task_valid_o),
        .npu_task_ready_i  (npu_task_ready_i),
        .npu_task_addr_o   (npu_task_addr_o),
        .npu_done_i        (npu_done_i),
        .cim_task_valid_o  (cim_task_valid_o),
        .cim_task_ready_i  (cim_task_ready_i),
        .cim_task_addr_o   (cim_task_addr_o),
        .cim_done_i        (cim_done_i),
        .schedule_finish_o (schedule_finish_o)
`ifdef DISPATCH_PERF_EN
        ,
        .perf_bubble_cycles_o (perf_bubble_cycles_o)
`endif
    );

    // Engine models: a task seen valid&ready at the negedge is accepted on the next posedge,
    // and its done pulse is sampled 'latency' cycles after that acceptance.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            npu_pend = 0; npu_done_i = 1'b0;
            cim_pend = 0; cim_done_i = 1'b0;
        end else begin
            npu_done_i = 1'b0;
            cim_done_i = 1'b0;
            if (npu_pend > 0) begin npu_pend--; if (npu_pend == 0) npu_done_i = 1'b1; end
            if (cim_pend > 0) begin cim_pend--; if (cim_pend == 0) cim_done_i = 1'b1; end
            if (npu_task_valid_o && npu_task_ready_i) begin npu_q.push_back(npu_task_addr_o); npu_pend = latency; end
            if (cim_task_valid_o && cim_task_ready_i) begin cim_q.push_back(cim_task_addr_o); cim_pend = latency; end
        end
    end

    always @(negedge clk_i) if (schedule_finish_o) finish_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_task(input string tag, input bit npu, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = 32'hDEAD_BEEF;
        if (npu && idx < npu_q.size()) obs = npu_q[idx];
        if (!npu && idx < cim_q.size()) obs = cim_q[idx];
        check(tag, obs, exp);
    endtask

    // Present a decision for one cycle; returns at the negedge one cycle after the handshake.
    task automatic run_sched(input logic st, input logic [1:0] bt, input logic [31:0] s0,
                             input logic [7:0] c0, input logic [31:0] s1, input logic [7:0] c1);
        n_npu0 = npu_q.size();
        n_cim0 = cim_q.size();
        fin0   = finish_cnt;
        @(posedge clk_i); #1;
        schedule_type_i = st; block_type_i = bt;
        block0_start_i = s0; block0_count_i = c0;
        block1_start_i = s1; block1_count_i = c1;
        sched_valid_i = 1'b1;
        @(posedge clk_i); #1;
        sched_valid_i = 1'b0;
        @(negedge clk_i);
        check("ready_low_after_hs", {31'd0, sched_ready_o}, 32'd1 - 32'd1);
    endtask

    task automatic wait_finish(input string tag);
        int cyc;
        cyc = 0;
        while (finish_cnt == fin0 && cyc < 2000) begin @(negedge clk_i); cyc++; end
        check({tag, "_timeout"}, (cyc < 2000) ? 32'd0 : 32'd1, 32'd0);
        repeat (3) @(negedge clk_i);
        check({tag, "_finish_pulses"}, 32'(finish_cnt - fin0), 32'd1);
        check({tag, "_ready_back"}, {31'd0, sched_ready_o}, 32'd1);
    endtask

    initial begin
        // 1: reset state and quiet idle
        repeat (2) @(negedge clk_i);
        check("rst_ready", {31'd0, sched_ready_o}, 32'd1);
        check("rst_npu_valid", {31'd0, npu_task_valid_o}, 32'd0);
        check("rst_cim_valid", {31'd0, cim_task_valid_o}, 32'd0);
        check("rst_npu_addr", npu_task_addr_o, 32'd0);
        check("rst_cim_addr", cim_task_addr_o, 32'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        check("idle_no_finish", 32'(finish_cnt), 32'd0);
        check("idle_ready", {31'd0, sched_ready_o}, 32'd1);

        // 2: CIM=block0 forward (start 4, 2 layers), NPU=block1 backward (start 10, 3 layers)
        latency = 2;
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_BACKWARD, 32'd4, 8'd2, 32'd10, 8'd3);
        check("t2_cim_valid_first", {31'd0, cim_task_valid_o}, 32'd1);
        check("t2_cim_addr_first", cim_task_addr_o, 32'h104);
        check("t2_npu_valid_first", {31'd0, npu_task_valid_o}, 32'd1);
        check("t2_npu_addr_first", npu_task_addr_o, 32'h20A);
        wait_finish("t2");
        check("t2_cim_cnt", 32'(cim_q.size() - n_cim0), 32'd2);
        check("t2_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd3);
        check_task("t2_cim0", 1'b0, n_cim0 + 0, 32'h104);
        check_task("t2_cim1", 1'b0, n_cim0 + 1, 32'h105);
        check_task("t2_npu0", 1'b1, n_npu0 + 0, 32'h20A);
        check_task("t2_npu1", 1'b1, n_npu0 + 1, 32'h20B);
        check_task("t2_npu2", 1'b1, n_npu0 + 2, 32'h20C);

        // 3: swapped mapping, NPU stalls its ready for 5 cycles
        @(posedge clk_i); #1 npu_task_ready_i = 1'b0;
        run_sched(BLOCK0_NPU_BLOCK1_CIM, FORWARD_BACKWARD, 32'd4, 8'd2, 32'd10, 8'd3);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_stall_valid_%0d", i), {31'd0, npu_task_valid_o}, 32'd1);
            check($sformatf("t3_stall_addr_%0d", i), npu_task_addr_o, 32'h104);
            if (i < 4) @(negedge clk_i);
        end
        @(posedge clk_i); #1 npu_task_ready_i = 1'b1;
        wait_finish("t3");
        check("t3_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd2);
        check("t3_cim_cnt", 32'(cim_q.size() - n_cim0), 32'd3);
        check_task("t3_npu0", 1'b1, n_npu0 + 0, 32'h104);
        check_task("t3_npu1", 1'b1, n_npu0 + 1, 32'h105);
        check_task("t3_cim0", 1'b0, n_cim0 + 0, 32'h20A);
        check_task("t3_cim2", 1'b0, n_cim0 + 2, 32'h20C);

        // 4: block0 empty -> CIM idle, NPU runs one forward layer at 7
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_FORWARD, 32'd3, 8'd0, 32'd7, 8'd1);
        check("t4_cim_valid", {31'd0, cim_task_valid_o}, 32'd0);
        check("t4_npu_addr", npu_task_addr_o, 32'h107);
        wait_finish("t4");
        check("t4_cim_cnt", 32'(cim_q.size() - n_cim0), 32'd0);
        check("t4_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd1);
        check_task("t4_npu0", 1'b1, n_npu0, 32'h107);

        // 5: reset while the NPU waits on a long task, then a normal run
        latency = 6;
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_FORWARD, 32'd0, 8'd1, 32'd20, 8'd3);
        for (int i = 0; i < 50 && npu_q.size() == n_npu0; i++) @(negedge clk_i);
        check("t5_npu_accepted", 32'(npu_q.size() - n_npu0), 32'd1);
        @(posedge clk_i); #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("t5_rst_npu_valid", {31'd0, npu_task_valid_o}, 32'd0);
        check("t5_rst_cim_valid", {31'd0, cim_task_valid_o}, 32'd0);
        check("t5_rst_ready", {31'd0, sched_ready_o}, 32'd1);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        check("t5_no_finish", 32'(finish_cnt - fin0), 32'd0);
        check("t5_npu_quiet", 32'(npu_q.size() - n_npu0), 32'd1);
        latency = 2;
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_BACKWARD, 32'd4, 8'd2, 32'd10, 8'd3);
        wait_finish("t5b");
        check("t5b_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd3);
        check_task("t5b_npu2", 1'b1, n_npu0 + 2, 32'h20C);

        // 6: uneven blocks (1 vs 4 layers, latency 3) and an even split with simultaneous done
        latency = 3;
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_FORWARD, 32'd0, 8'd1, 32'h20, 8'd4);
        wait_finish("t6a");
        check("t6a_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd4);
        check_task("t6a_cim0", 1'b0, n_cim0, 32'h100);
        check_task("t6a_npu3", 1'b1, n_npu0 + 3, 32'h123);
`ifdef DISPATCH_PERF_EN
        check("t6a_bubble", perf_bubble_cycles_o, 32'd12);
`endif
        run_sched(BLOCK0_CIM_BLOCK1_NPU, BACKWARD_BACKWARD, 32'd5, 8'd2, 32'd9, 8'd2);
        wait_finish("t6b");
        check_task("t6b_cim1", 1'b0, n_cim0 + 1, 32'h206);
        check_task("t6b_npu1", 1'b1, n_npu0 + 1, 32'h20A);
`ifdef DISPATCH_PERF_EN
        check("t6b_bubble", perf_bubble_cycles_o, 32'd0);
`endif

        // 7: full-range count 255 must finish without index wrap
        latency = 1;
        run_sched(BLOCK0_CIM_BLOCK1_NPU, FORWARD_FORWARD, 32'd0, 8'hFF, 32'd0, 8'd0);
        wait_finish("t7");
        check("t7_cim_cnt", 32'(cim_q.size() - n_cim0), 32'd255);
        check_task("t7_cim_first", 1'b0, n_cim0, 32'h100);
        check_task("t7_cim_last", 1'b0, n_cim0 + 254, 32'h1FE);
        check("t7_npu_cnt", 32'(npu_q.size() - n_npu0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
